// File: rtl/act_quant_ctrl_if.sv
//==============================================================================
// Module      : act_quant_ctrl_if
// Description : Streaming signals of the activation-quantization sequencer:
//               accumulator handshake, quantizer side-band and SRAM write port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface act_quant_ctrl_if #(
    parameter int MAX_INPUT_WIDTH = 16,
    parameter int ADDR_WIDTH      = 12
);
    // Accumulator buffer handshake
    logic                         acc_vld;
    logic                         acc_rdy;
    // Quantizer array controls and result
    logic                         q_vld_i;
    logic [1:0]                   fmap_precision;
    logic [3:0]                   shift;
    logic [4:0]                   layer_num;
    logic                         q_vld_o;
    logic [8*MAX_INPUT_WIDTH-1:0] q_data_o;
    // Activation SRAM write port
    logic                         wr_en;
    logic                         wr_rdy;
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic [8*MAX_INPUT_WIDTH-1:0] wr_data;

    // Controller side
    modport master (
        input  acc_vld, q_vld_o, q_data_o, wr_rdy,
        output acc_rdy, q_vld_i, fmap_precision, shift, layer_num,
               wr_en, wr_addr, wr_data
    );

    // Environment side (accumulator buffer, quantizer, SRAM)
    modport slave (
        output acc_vld, q_vld_o, q_data_o, wr_rdy,
        input  acc_rdy, q_vld_i, fmap_precision, shift, layer_num,
               wr_en, wr_addr, wr_data
    );
endinterface

`default_nettype wire

// File: rtl/act_quant_ctrl.sv
//==============================================================================
// Module      : act_quant_ctrl
// Description : Layer sequencer for the activation-quantization stage. Holds a
//               per-layer configuration table, drives static quantizer controls,
//               meters accumulator vectors with a credit counter and writes the
//               quantized vectors to SRAM through a small output FIFO.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module act_quant_ctrl #(
    parameter int NUM_LAYERS      = 21,
    parameter int MAX_INPUT_WIDTH = 16,
    parameter int ADDR_WIDTH      = 12,
    parameter int CNT_WIDTH       = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rstn,
    input  wire logic                  cfg_we,
    input  wire logic [4:0]            cfg_addr,
    input  wire logic [1:0]            cfg_precision,
    input  wire logic [3:0]            cfg_shift,
    input  wire logic [CNT_WIDTH-1:0]  cfg_count,
    input  wire logic [ADDR_WIDTH-1:0] cfg_base,
    input  wire logic                  start,
    input  wire logic [4:0]            start_layer,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       ovf_err,
    act_quant_ctrl_if.master           bus
);
    localparam int DW = 8 * MAX_INPUT_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] c_CREDITS = (PW+1)'(FIFO_DEPTH);
    localparam logic [4:0]  c_LAYERS  = 5'(NUM_LAYERS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    logic [1:0]            r_tbl_prec  [NUM_LAYERS];
    logic [3:0]            r_tbl_shift [NUM_LAYERS];
    logic [CNT_WIDTH-1:0]  r_tbl_count [NUM_LAYERS];
    logic [ADDR_WIDTH-1:0] r_tbl_base  [NUM_LAYERS];
    logic [4:0]            r_sel;
    logic [1:0]            r_prec;
    logic [3:0]            r_shift;
    logic [4:0]            r_layer;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  r_issued;
    logic [CNT_WIDTH-1:0]  r_written;
    logic [PW:0]           r_outst;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic                  r_err;
    logic                  r_ovf;
    logic [DW-1:0]         r_mem [FIFO_DEPTH];
    logic [PW:0]           r_wptr;
    logic [PW:0]           r_rptr;

    logic w_empty, w_full, w_acc_rdy, w_issue, w_pop, w_push;

    // FIFO status and handshakes, all decoded from registered state
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_acc_rdy = (r_state == S_RUN) && (r_issued < r_count) && (r_outst < c_CREDITS);
    assign w_issue   = bus.acc_vld && w_acc_rdy;
    assign w_pop     = !w_empty && bus.wr_rdy;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign w_push    = bus.q_vld_o && (!w_full || w_pop);

    assign bus.acc_rdy        = w_acc_rdy;
    assign bus.q_vld_i        = w_issue;
    assign bus.fmap_precision = r_prec;
    assign bus.shift          = r_shift;
    assign bus.layer_num      = r_layer;
    assign bus.wr_en          = !w_empty;
    assign bus.wr_addr        = r_wr_addr;
    assign bus.wr_data        = r_mem[r_rptr[PW-1:0]];
    assign busy               = (r_state != S_IDLE);
    assign done               = (r_state == S_DONE);
    assign err                = r_err;
    assign ovf_err            = r_ovf;

    // Configuration table: writable in any state, out-of-range entries ignored
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                r_tbl_prec[i]  <= '0;
                r_tbl_shift[i] <= '0;
                r_tbl_count[i] <= '0;
                r_tbl_base[i]  <= '0;
            end
        end else if (cfg_we && (cfg_addr < c_LAYERS)) begin
            r_tbl_prec[cfg_addr]  <= cfg_precision;
            r_tbl_shift[cfg_addr] <= cfg_shift;
            r_tbl_count[cfg_addr] <= cfg_count;
            r_tbl_base[cfg_addr]  <= cfg_base;
        end
    end

    // Layer sequencer: latches controls in LOAD, tracks issue/write credits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_prec    <= '0;
            r_shift   <= '0;
            r_layer   <= '0;
            r_count   <= '0;
            r_issued  <= '0;
            r_written <= '0;
            r_outst   <= '0;
            r_wr_addr <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            // Every write lands at the next address; LOAD below overrides
            if (w_pop) begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
            if ((r_state == S_RUN) || (r_state == S_DRAIN)) begin
                if (w_issue) begin
                    r_issued <= r_issued + 1'b1;
                end
                if (w_pop) begin
                    r_written <= r_written + 1'b1;
                end
                if (w_issue && !w_pop) begin
                    r_outst <= r_outst + 1'b1;
                end else if (!w_issue && w_pop) begin
                    r_outst <= r_outst - 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (start_layer < c_LAYERS) begin
                            r_sel   <= start_layer;
                            r_state <= S_LOAD;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_prec    <= r_tbl_prec[r_sel];
                    r_shift   <= r_tbl_shift[r_sel];
                    r_layer   <= r_sel;
                    r_count   <= r_tbl_count[r_sel];
                    r_issued  <= '0;
                    r_written <= '0;
                    r_outst   <= '0;
                    r_wr_addr <= r_tbl_base[r_sel];
                    r_state   <= (r_tbl_count[r_sel] == '0) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    if (w_issue && ((r_issued + 1'b1) == r_count)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_pop && ((r_written + 1'b1) == r_count)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output FIFO pointers and sticky overflow flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (bus.q_vld_o && !w_push) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are qualified by the pointers only
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[PW-1:0]] <= bus.q_data_o;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_act_quant_ctrl.sv
//==============================================================================
// Module      : tb_act_quant_ctrl
// Description : Directed self-checking bench for act_quant_ctrl with a
//               two-cycle quantizer model and an SRAM write-port checker.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_act_quant_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [1:0]  cfg_precision;
    logic [3:0]  cfg_shift;
    logic [15:0] cfg_count;
    logic [11:0] cfg_base;
    logic        start;
    logic [4:0]  start_layer;
    logic        busy, done, err, ovf_err;

    int n_err = 0;
    int n_chk = 0;

    act_quant_ctrl_if bus ();

    act_quant_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_precision(cfg_precision),
        .cfg_shift    (cfg_shift),
        .cfg_count    (cfg_count),
        .cfg_base     (cfg_base),
        .start        (start),
        .start_layer  (start_layer),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .ovf_err      (ovf_err),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Distinct byte pattern per vector index within a layer
    function automatic logic [127:0] pat(input int k);
        logic [7:0] b;
        b = 8'(k * 37 + 11);
        return {16{b}};
    endfunction

    // Quantizer model: fixed two-cycle latency, data numbered per layer
    int           m_id;
    logic         m_s1_vld, m_s2_vld;
    logic [127:0] m_s1_dat, m_s2_dat;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_id     <= 0;
            m_s1_vld <= 1'b0;
            m_s2_vld <= 1'b0;
            m_s1_dat <= '0;
            m_s2_dat <= '0;
        end else begin
            m_s1_vld <= bus.q_vld_i;
            m_s1_dat <= pat(m_id);
            m_s2_vld <= m_s1_vld;
            m_s2_dat <= m_s1_dat;
            if (done) m_id <= 0;
            else if (bus.q_vld_i) m_id <= m_id + 1;
        end
    end
    assign bus.q_vld_o  = m_s2_vld;
    assign bus.q_data_o = m_s2_dat;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [1:0] p, input logic [3:0] s,
                             input logic [15:0] c, input logic [11:0] b);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_precision = p; cfg_shift = s;
        cfg_count = c; cfg_base = b;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] layer);
        @(negedge clk);
        start = 1'b1; start_layer = layer;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs a started layer to completion, checking every SRAM write
    task automatic run_layer(input string nm, input int exp_cnt, input logic [11:0] base,
                             input int stall, input int inj);
        int n = 0, iss = 0, cyc = 0, last_pop = -10, done_cyc = -1;
        logic [11:0] ea;
        while (cyc < 400 && done_cyc < 0) begin
            @(negedge clk);
            bus.acc_vld = 1'b1;
            bus.wr_rdy  = (cyc >= stall);
            start       = (cyc == inj);
            start_layer = 5'd3;
            #1;
            if (stall > 0 && cyc == stall) begin
                chk({nm, "_stall_issues"}, iss, 4);
                chk({nm, "_stall_acc_rdy"}, bus.acc_rdy, 1'b0);
            end
            if (bus.q_vld_i) iss++;
            if (bus.wr_en && bus.wr_rdy) begin
                ea = base + 12'(n);
                chk({nm, "_wr_addr"}, bus.wr_addr, ea);
                chk({nm, "_wr_data"}, bus.wr_data, pat(n));
                n++;
                last_pop = cyc;
            end
            if (done) done_cyc = cyc;
            cyc++;
        end
        start = 1'b0;
        chk({nm, "_done_seen"}, (done_cyc >= 0), 1'b1);
        chk({nm, "_writes"}, n, exp_cnt);
        chk({nm, "_issues"}, iss, exp_cnt);
        chk({nm, "_done_latency"}, done_cyc - last_pop, 1);
        chk({nm, "_ovf"}, ovf_err, 1'b0);
        @(negedge clk);
        bus.acc_vld = 1'b0;
        #1;
        chk({nm, "_done_one_pulse"}, done, 1'b0);
        chk({nm, "_busy_end"}, busy, 1'b0);
    endtask

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int iss;
        rstn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_precision = '0; cfg_shift = '0;
        cfg_count = '0; cfg_base = '0; start = 1'b0; start_layer = '0;
        bus.acc_vld = 1'b0; bus.wr_rdy = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_wr_en", bus.wr_en, 1'b0);
        chk("rst_wr_addr", bus.wr_addr, 12'h000);
        chk("rst_layer", bus.layer_num, 5'd0);
        rstn = 1'b1;

        // Basic layer: 8 vectors at 0x100
        cfg_write(5'd3, 2'd2, 4'd5, 16'd8, 12'h100);
        do_start(5'd3);
        #1;
        chk("t1_load_busy", busy, 1'b1);
        chk("t1_load_acc_rdy", bus.acc_rdy, 1'b0);
        run_layer("t1", 8, 12'h100, 0, -1);
        chk("t1_prec", bus.fmap_precision, 2'd2);
        chk("t1_shift", bus.shift, 4'd5);
        chk("t1_layer", bus.layer_num, 5'd3);

        // Back-pressure for 20 cycles plus a start while busy
        do_start(5'd3);
        run_layer("t2", 8, 12'h100, 20, 5);

        // Zero-length layer
        cfg_write(5'd4, 2'd1, 4'd3, 16'd0, 12'h200);
        bus.acc_vld = 1'b1; bus.wr_rdy = 1'b1;
        @(negedge clk);
        start = 1'b1; start_layer = 5'd4;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("t3_load_busy", busy, 1'b1);
        chk("t3_load_done", done, 1'b0);
        @(negedge clk); #1;
        chk("t3_done", done, 1'b1);
        chk("t3_acc_rdy", bus.acc_rdy, 1'b0);
        chk("t3_wr_en", bus.wr_en, 1'b0);
        chk("t3_prec", bus.fmap_precision, 2'd1);
        @(negedge clk); #1;
        chk("t3_done_end", done, 1'b0);
        chk("t3_busy_end", busy, 1'b0);
        bus.acc_vld = 1'b0;

        // Invalid layer index
        @(negedge clk);
        start = 1'b1; start_layer = 5'd25;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("t4_err", err, 1'b1);
        chk("t4_busy", busy, 1'b0);
        @(negedge clk); #1;
        chk("t4_err_pulse", err, 1'b0);
        chk("t4_busy_after", busy, 1'b0);

        // Address wrap
        cfg_write(5'd7, 2'd0, 4'd1, 16'd4, 12'hFFE);
        do_start(5'd7);
        run_layer("t5", 4, 12'hFFE, 0, -1);
        chk("t5_addr_after", bus.wr_addr, 12'h002);

        // Reset in the middle of a layer
        cfg_write(5'd3, 2'd2, 4'd5, 16'd8, 12'h100);
        do_start(5'd3);
        bus.wr_rdy = 1'b1; bus.acc_vld = 1'b1;
        iss = 0;
        for (int c = 0; c < 50 && iss < 3; c++) begin
            @(negedge clk); #1;
            if (bus.q_vld_i) iss++;
        end
        chk("t6_pre_issues", iss, 3);
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_ovf", ovf_err, 1'b0);
        chk("t6_acc_rdy", bus.acc_rdy, 1'b0);
        chk("t6_q_vld_i", bus.q_vld_i, 1'b0);
        chk("t6_wr_en", bus.wr_en, 1'b0);
        chk("t6_prec", bus.fmap_precision, 2'd0);
        chk("t6_shift", bus.shift, 4'd0);
        chk("t6_layer", bus.layer_num, 5'd0);
        chk("t6_wr_addr", bus.wr_addr, 12'h000);
        bus.acc_vld = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        cfg_write(5'd3, 2'd2, 4'd5, 16'd8, 12'h100);
        do_start(5'd3);
        run_layer("t6r", 8, 12'h100, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
